q_fifo_w8_d17_srl_ctrl: RTL and testbench

- Stream FIFO that carries packed i4xi4 operand bytes (two signed 4-bit values per 8-bit word) between Linear_Layer dataflow tasks.
- Wraps a shift-register storage array with pointer, full/empty and occupancy control.
- Exposes HLS ap_fifo-style write and read handshakes: the producer task pushes on the write side, the consumer task pops on the read side.
- First-word fall-through: the head word is visible on if_dout while if_empty_n=1.

---
 rtl/q_fifo_w8_d17_srl_ctrl.sv | 79 +++++++
 tb/tb_q_fifo_w8_d17_srl_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/q_fifo_w8_d17_srl_ctrl.sv
// Shift-register stream FIFO with first-word fall-through and ap_fifo-style handshakes.
// Carries packed i4xi4 operand bytes between dataflow tasks; lane packing is opaque here.
module q_fifo_w8_d17_srl_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 5,
    parameter int DEPTH        = 17,
    parameter int AFULL_THRESH = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic [ADDR_WIDTH-1:0] if_count,
    output logic                  if_almost_full
);

    localparam logic [ADDR_WIDTH-1:0] PTR_EMPTY = '1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_C   = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] THRESH_C  = ADDR_WIDTH'(AFULL_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] ptr_nxt;
    logic [ADDR_WIDTH-1:0] count_nxt;
    logic                  push;
    logic                  pop;

    assign push = if_write & if_write_ce & if_full_n;
    assign pop  = if_read & if_read_ce & if_empty_n;

    // Oldest word sits at entry[ptr]; ptr is all-ones when empty, so gate the read.
    assign if_dout = if_empty_n ? mem[ptr] : '0;

    always_comb begin
        ptr_nxt   = ptr;
        count_nxt = if_count;
        if (push && !pop) begin
            ptr_nxt   = ptr + 1'b1;
            count_nxt = if_count + 1'b1;
        end else if (pop && !push) begin
            ptr_nxt   = ptr - 1'b1;
            count_nxt = if_count - 1'b1;
        end
    end

    // Storage: plain shift array, never reset; stale words become unreachable via ptr.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[0] <= if_din;
            for (int i = DEPTH - 1; i > 0; i--) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    // Control: pointer, occupancy and registered flags all follow the next count.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr            <= PTR_EMPTY;
            if_count       <= '0;
            if_empty_n     <= 1'b0;
            if_full_n      <= 1'b1;
            if_almost_full <= 1'b0;
        end else begin
            ptr            <= ptr_nxt;
            if_count       <= count_nxt;
            if_empty_n     <= (count_nxt != '0);
            if_full_n      <= (count_nxt != DEPTH_C);
            if_almost_full <= (count_nxt >= THRESH_C);
        end
    end

endmodule

// File: tb/tb_q_fifo_w8_d17_srl_ctrl.sv
// Scoreboard bench for q_fifo_w8_d17_srl_ctrl: pushed words queue up, popped words are compared.
module tb_q_fifo_w8_d17_srl_ctrl;

    localparam int DEPTH  = 17;
    localparam int THRESH = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       if_full_n;
    logic       if_write_ce;
    logic       if_write;
    logic [7:0] if_din;
    logic       if_empty_n;
    logic       if_read_ce;
    logic       if_read;
    logic [7:0] if_dout;
    logic [4:0] if_count;
    logic       if_almost_full;

    int         vectors = 0;
    int         miscompares = 0;
    int         mcount = 0;
    logic [7:0] sb [$];

    q_fifo_w8_d17_srl_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .if_full_n      (if_full_n),
        .if_write_ce    (if_write_ce),
        .if_write       (if_write),
        .if_din         (if_din),
        .if_empty_n     (if_empty_n),
        .if_read_ce     (if_read_ce),
        .if_read        (if_read),
        .if_dout        (if_dout),
        .if_count       (if_count),
        .if_almost_full (if_almost_full)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; model decides push/pop from its own occupancy.
    task automatic step(input logic w, input logic wce, input logic r, input logic rce,
                        input logic [7:0] din);
        logic       mpush;
        logic       mpop;
        logic [7:0] exp;
        @(negedge clk);
        reset = 1'b0; if_write = w; if_write_ce = wce; if_read = r; if_read_ce = rce; if_din = din;
        #1;
        mpush = w && wce && (mcount < DEPTH);
        mpop  = r && rce && (mcount > 0);
        if (mpop) begin
            exp = sb.pop_front();
            vectors++;
            if (if_dout !== exp) begin
                miscompares++;
                $display("FAIL pop_data: got %02h expected %02h", if_dout, exp);
            end
        end
        if (mpush) sb.push_back(din);
        if (mpush && !mpop) mcount++;
        else if (mpop && !mpush) mcount--;
        @(posedge clk); #1;
        vectors++;
        if (if_count !== 5'(mcount) || if_empty_n !== (mcount != 0) || if_full_n !== (mcount != DEPTH)
            || if_almost_full !== (mcount >= THRESH)) begin
            miscompares++;
            $display("FAIL flags: count=%0d e_n=%b f_n=%b af=%b expected count=%0d", if_count,
                     if_empty_n, if_full_n, if_almost_full, mcount);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic drain();
        while (mcount > 0) step(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; if_write = 1'b0; if_write_ce = 1'b1; if_read = 1'b0; if_read_ce = 1'b1; if_din = 8'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        sb.delete(); mcount = 0;
        vectors++;
        if (if_empty_n !== 1'b0 || if_full_n !== 1'b1 || if_count !== 5'd0 || if_almost_full !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: e_n=%b f_n=%b count=%0d af=%b expected 0 1 0 0",
                     if_empty_n, if_full_n, if_count, if_almost_full);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, 8'(i));
            vectors++;
            if (if_almost_full !== (i >= THRESH)) begin
                miscompares++;
                $display("FAIL almost_full at %0d: got %b expected %b", i, if_almost_full, i >= THRESH);
            end
        end
        vectors++;
        if (if_full_n !== 1'b0 || if_count !== 5'd17) begin
            miscompares++;
            $display("FAIL full: f_n=%b count=%0d expected 0 17", if_full_n, if_count);
        end
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF);
        vectors++;
        if (if_count !== 5'd17) begin
            miscompares++;
            $display("FAIL overflow_drop: count=%0d expected 17", if_count);
        end
        for (int i = 1; i <= DEPTH; i++) begin
            vectors++;
            if (if_dout !== 8'(i)) begin
                miscompares++;
                $display("FAIL drain_order %0d: got %02h expected %02h", i, if_dout, 8'(i));
            end
            step(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        end
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        vectors++;
        if (if_empty_n !== 1'b0 || if_count !== 5'd0) begin
            miscompares++;
            $display("FAIL underflow: e_n=%b count=%0d expected 0 0", if_empty_n, if_count);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'hA1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'hA2);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1, 8'hB0 + 8'(k));
            vectors++;
            if (if_count !== 5'd2) begin
                miscompares++;
                $display("FAIL simul_count: got %0d expected 2", if_count);
            end
        end
        drain();
    endtask

    task automatic test_full_pop_write();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 8'h40 + 8'(i));
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'hEE);
        vectors++;
        if (if_count !== 5'd16 || if_full_n !== 1'b1) begin
            miscompares++;
            $display("FAIL full_pop_write: count=%0d f_n=%b expected 16 1", if_count, if_full_n);
        end
        drain();
    endtask

    task automatic test_write_ce();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b1, 8'h11);
        vectors++;
        if (if_count !== 5'd0 || if_empty_n !== 1'b0) begin
            miscompares++;
            $display("FAIL write_ce_gate: count=%0d e_n=%b expected 0 0", if_count, if_empty_n);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h5C);
        vectors++;
        if (if_count !== 5'd1 || if_dout !== 8'h5C) begin
            miscompares++;
            $display("FAIL write_ce_push: count=%0d dout=%02h expected 1 5c", if_count, if_dout);
        end
        drain();
    endtask

    task automatic test_empty_rw();
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h3E);
        vectors++;
        if (if_count !== 5'd1 || if_dout !== 8'h3E) begin
            miscompares++;
            $display("FAIL empty_rw: count=%0d dout=%02h expected 1 3e", if_count, if_dout);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 8'h90 + 8'(i));
        @(negedge clk);
        reset = 1'b1; if_write = 1'b1; if_din = 8'h99;
        @(posedge clk); #1;
        sb.delete(); mcount = 0;
        vectors++;
        if (if_empty_n !== 1'b0 || if_full_n !== 1'b1 || if_count !== 5'd0 || if_almost_full !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: e_n=%b f_n=%b count=%0d af=%b expected 0 1 0 0",
                     if_empty_n, if_full_n, if_count, if_almost_full);
        end
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h77);
        vectors++;
        if (if_dout !== 8'h77) begin
            miscompares++;
            $display("FAIL reset_mid_push: dout=%02h expected 77", if_dout);
        end
        drain();
    endtask

    initial begin
        reset = 1'b1; if_write = 1'b0; if_write_ce = 1'b1; if_read = 1'b0; if_read_ce = 1'b1; if_din = 8'h00;
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_full_pop_write();
        test_write_ce();
        test_empty_rw();
        test_reset_mid();
        idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
